// File: rtl/sb_pkg.sv
// Shared types and constants for the load scoreboard: tag layout, x0 tag, default depth.
package sb_pkg;

  localparam int TAG_W         = 7;
  localparam int TAG_VALID     = 6;
  localparam int TAG_FREG      = 5;
  localparam int REGNUM_W      = 5;
  localparam int DEPTH_DEFAULT = 4;

  typedef logic [TAG_W-1:0] tag_t;

  // Integer register zero: valid bit set, integer file, regnum 0.
  localparam tag_t X0_TAG = 7'b100_0000;

  function automatic logic tag_tracked(input tag_t t);
    return t[TAG_VALID] && (t != X0_TAG);
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order circular queue of outstanding load tags; exports storage, per-entry valid and head marker.
module tag_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int TAGW  = TAG_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [TAGW-1:0]               push_tag_i,
  output logic [DEPTH-1:0][TAGW-1:0]    entries_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH-1:0]              head_onehot_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][TAGW-1:0] mem_q, mem_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;

  // Caller never pushes into a full queue without a pop, nor pops an empty one.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_tag_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid_o = '0;
    head_onehot_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off              = PW'(i) - rd_ptr_q;
      entry_valid_o[i] = (CW'(off) < count_q);
      head_onehot_o[i] = (PW'(i) == rd_ptr_q);
    end
  end

  assign entries_o = mem_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/load_scoreboard.sv
// Load-use scoreboard: stalls issue on pending load destinations and steers wb_memdata forwarding.
// Optional SCOREBOARD_CHECK_EN adds a sticky err output for unexpected or out-of-order returns.
module load_scoreboard
  import sb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int TAGW  = TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [TAGW-1:0]            issue_rs1,
  input  logic [TAGW-1:0]            issue_rs2,
  input  logic                       issue_is_load,
  input  logic [TAGW-1:0]            issue_rd,
  input  logic                       wb_mre,
  input  logic [TAGW-1:0]            wb_rd,
  output logic                       stall,
  output logic                       fwd1,
  output logic                       fwd2,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       full
`ifdef SCOREBOARD_CHECK_EN
  ,
  output logic                       err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][TAGW-1:0] entries;
  logic [DEPTH-1:0]           entry_valid;
  logic [DEPTH-1:0]           head_onehot;
  logic [CW-1:0]              count;
  logic                       fifo_full;
  logic                       push, pop;
  logic                       haz1, haz2, cap_haz;

  function automatic logic tracked(input logic [TAGW-1:0] t);
    return t[TAGW-1] && (t != TAGW'(X0_TAG));
  endfunction

  tag_fifo #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) u_tag_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .pop_i         (pop),
    .push_tag_i    (issue_rd),
    .entries_o     (entries),
    .entry_valid_o (entry_valid),
    .head_onehot_o (head_onehot),
    .count_o       (count),
    .full_o        (fifo_full)
  );

  // The head leaving this cycle no longer blocks; a younger duplicate still does.
  always_comb begin
    pop  = wb_mre && (count != '0);
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && !(pop && head_onehot[i])) begin
        if (entries[i] == issue_rs1) haz1 = 1'b1;
        if (entries[i] == issue_rs2) haz2 = 1'b1;
      end
    end
    haz1    = haz1 && tracked(issue_rs1);
    haz2    = haz2 && tracked(issue_rs2);
    cap_haz = issue_is_load && fifo_full && !wb_mre;
    stall   = issue_valid && (haz1 || haz2 || cap_haz);
    fwd1    = issue_valid && issue_rs1[TAGW-1] && wb_mre && (issue_rs1 == wb_rd);
    fwd2    = issue_valid && issue_rs2[TAGW-1] && wb_mre && (issue_rs2 == wb_rd);
    push    = issue_valid && issue_is_load && !stall && tracked(issue_rd);
  end

  assign pending = count;
  assign full    = fifo_full;

`ifdef SCOREBOARD_CHECK_EN
  logic [TAGW-1:0] head_tag;
  logic            err_q, err_d;

  always_comb begin
    head_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head_onehot[i]) head_tag = entries[i];
    end
    err_d = err_q;
    if (wb_mre && ((count == '0) || (wb_rd != head_tag))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// Self-checking bench for load_scoreboard: directed vector table, hand sequences, random vs queue model.
module tb_load_scoreboard;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, issue_valid, issue_is_load, wb_mre;
  logic [6:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic       stall, fwd1, fwd2, full;
  logic [2:0] pending;
`ifdef SCOREBOARD_CHECK_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  load_scoreboard #(.DEPTH(DEPTH), .TAGW(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_is_load (issue_is_load),
    .issue_rd      (issue_rd),
    .wb_mre        (wb_mre),
    .wb_rd         (wb_rd),
    .stall         (stall),
    .fwd1          (fwd1),
    .fwd2          (fwd2),
    .pending       (pending),
    .full          (full)
`ifdef SCOREBOARD_CHECK_EN
    ,
    .err           (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the list of outstanding load destinations, oldest first.
  logic [6:0] mq[$];
  logic       m_stall, m_f1, m_f2, m_full;
  int         m_pend;

  function automatic logic trk(input logic [6:0] t);
    return t[6] && (t != 7'h40);
  endfunction

  function automatic logic waits_on(input logic [6:0] rs, input logic popping);
    if (!trk(rs)) return 1'b0;
    for (int j = (popping ? 1 : 0); j < mq.size(); j++)
      if (mq[j] == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle at negedge, compute model expectations, then advance the model.
  task automatic step(input logic r, input logic iv, input logic [6:0] rs1, input logic [6:0] rs2,
                      input logic ld, input logic [6:0] rd, input logic mre, input logic [6:0] wrd);
    logic popping, accepted;
    @(negedge clk);
    rst = r; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_is_load = ld; issue_rd = rd; wb_mre = mre; wb_rd = wrd;
    #1;
    popping  = mre && (mq.size() != 0);
    m_pend   = mq.size();
    m_full   = (mq.size() == DEPTH);
    m_stall  = iv && (waits_on(rs1, popping) || waits_on(rs2, popping) || (ld && m_full && !mre));
    m_f1     = iv && rs1[6] && mre && (rs1 == wrd);
    m_f2     = iv && rs2[6] && mre && (rs2 == wrd);
    accepted = iv && ld && !m_stall && trk(rd);
    if (r) mq.delete();
    else begin
      if (popping) void'(mq.pop_front());
      if (accepted) mq.push_back(rd);
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00, 1'b0, 7'h00);
  endtask

  typedef struct {
    logic       iv;
    logic [6:0] rs1, rs2;
    logic       ld;
    logic [6:0] rd;
    logic       mre;
    logic [6:0] wbrd;
    logic       e_stall, e_f1, e_f2;
    int         e_pend;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [6:0] rs1, input logic [6:0] rs2, input logic ld,
                     input logic [6:0] rd, input logic mre, input logic [6:0] wbrd,
                     input logic es, input logic ef1, input logic ef2, input int ep, input logic efull);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.ld = ld; v.rd = rd; v.mre = mre; v.wbrd = wbrd;
    v.e_stall = es; v.e_f1 = ef1; v.e_f2 = ef2; v.e_pend = ep; v.e_full = efull;
    vecs.push_back(v);
  endtask

  logic [6:0] pool [7];

  initial begin
    pool = '{7'h40, 7'h41, 7'h42, 7'h43, 7'h61, 7'h62, 7'h05};

    // load x1, dependent add stalls, then forwarded on return
    add(1, 7'h00, 7'h00, 1, 7'h41, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h41, 7'h00, 0, 7'h00, 0, 7'h00,  1, 0, 0, 1, 0);
    add(1, 7'h41, 7'h00, 0, 7'h00, 1, 7'h41,  0, 1, 0, 1, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    // f3 load does not alias x3
    add(1, 7'h00, 7'h00, 1, 7'h63, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h00, 7'h43, 0, 7'h00, 0, 7'h00,  0, 0, 0, 1, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h63,  0, 0, 0, 1, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    // x0 is never tracked
    add(1, 7'h00, 7'h00, 1, 7'h40, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h40, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    // fill to capacity, fifth load stalls, then accepted alongside a return
    add(1, 7'h00, 7'h00, 1, 7'h41, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h00, 7'h00, 1, 7'h42, 0, 7'h00,  0, 0, 0, 1, 0);
    add(1, 7'h00, 7'h00, 1, 7'h43, 0, 7'h00,  0, 0, 0, 2, 0);
    add(1, 7'h00, 7'h00, 1, 7'h44, 0, 7'h00,  0, 0, 0, 3, 0);
    add(1, 7'h00, 7'h00, 1, 7'h45, 0, 7'h00,  1, 0, 0, 4, 1);
    add(1, 7'h00, 7'h00, 1, 7'h45, 1, 7'h41,  0, 0, 0, 4, 1);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 4, 1);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h42,  0, 0, 0, 4, 1);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h43,  0, 0, 0, 3, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h44,  0, 0, 0, 2, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h45,  0, 0, 0, 1, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    // WAW on x5: consumer stalls on the younger copy while forwarding the older
    add(1, 7'h00, 7'h00, 1, 7'h45, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h00, 7'h00, 1, 7'h45, 0, 7'h00,  0, 0, 0, 1, 0);
    add(1, 7'h45, 7'h00, 0, 7'h00, 1, 7'h45,  1, 1, 0, 2, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h45,  0, 0, 0, 1, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    // single pending on rs2 returning now: forward, no stall
    add(1, 7'h00, 7'h00, 1, 7'h45, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h00, 7'h45, 0, 7'h00, 1, 7'h45,  0, 0, 1, 1, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    // invalid-bit tag never tracked; stray return while empty ignored
    add(1, 7'h00, 7'h00, 1, 7'h05, 0, 7'h00,  0, 0, 0, 0, 0);
    add(1, 7'h05, 7'h05, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 1, 7'h41,  0, 0, 0, 0, 0);
    add(0, 7'h00, 7'h00, 0, 7'h00, 0, 7'h00,  0, 0, 0, 0, 0);

    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_stall", int'(stall), 0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(1'b0, vecs[k].iv, vecs[k].rs1, vecs[k].rs2, vecs[k].ld, vecs[k].rd,
           vecs[k].mre, vecs[k].wbrd);
      chk($sformatf("vec%0d_stall", k), int'(stall), int'(vecs[k].e_stall));
      chk($sformatf("vec%0d_fwd1", k), int'(fwd1), int'(vecs[k].e_f1));
      chk($sformatf("vec%0d_fwd2", k), int'(fwd2), int'(vecs[k].e_f2));
      chk($sformatf("vec%0d_pending", k), int'(pending), vecs[k].e_pend);
      chk($sformatf("vec%0d_full", k), int'(full), int'(vecs[k].e_full));
    end

    // reset with loads outstanding clears the queue; late returns are ignored
    step(1'b0, 1'b1, 7'h00, 7'h00, 1'b1, 7'h41, 1'b0, 7'h00);
    step(1'b0, 1'b1, 7'h00, 7'h00, 1'b1, 7'h42, 1'b0, 7'h00);
    idle(1'b1);
    chk("rst_mid_pending_before", int'(pending), 2);
    step(1'b0, 1'b1, 7'h41, 7'h42, 1'b0, 7'h00, 1'b1, 7'h41);
    chk("rst_mid_pending_after", int'(pending), 0);
    chk("rst_mid_stall", int'(stall), 0);
    chk("rst_mid_fwd1", int'(fwd1), 1);
    idle(1'b0);
    chk("rst_mid_late_return", int'(pending), 0);

`ifdef SCOREBOARD_CHECK_EN
    idle(1'b0);
    chk("err_clear", int'(err), 0);
    step(1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1, 7'h41);
    idle(1'b0);
    chk("err_empty_set", int'(err), 1);
    idle(1'b0);
    idle(1'b0);
    chk("err_sticky", int'(err), 1);
    idle(1'b1);
    idle(1'b0);
    chk("err_rst_clear", int'(err), 0);
    step(1'b0, 1'b1, 7'h00, 7'h00, 1'b1, 7'h41, 1'b0, 7'h00);
    step(1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1, 7'h41);
    idle(1'b0);
    chk("err_good_return", int'(err), 0);
    step(1'b0, 1'b1, 7'h00, 7'h00, 1'b1, 7'h41, 1'b0, 7'h00);
    step(1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1, 7'h42);
    idle(1'b0);
    chk("err_order_set", int'(err), 1);
    idle(1'b1);
    idle(1'b0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic       r, iv, ld, mre;
      logic [6:0] rs1, rs2, rd, wrd;
      r   = ($urandom_range(0, 199) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 1) == 1);
      rs1 = pool[$urandom_range(0, 6)];
      rs2 = pool[$urandom_range(0, 6)];
      rd  = pool[$urandom_range(0, 6)];
      mre = ($urandom_range(0, 2) == 0);
      wrd = pool[$urandom_range(0, 6)];
      if (mq.size() != 0 && $urandom_range(0, 4) != 0) wrd = mq[0];
      step(r, iv, rs1, rs2, ld, rd, mre, wrd);
      chk("rnd_stall", int'(stall), int'(m_stall));
      chk("rnd_fwd1", int'(fwd1), int'(m_f1));
      chk("rnd_fwd2", int'(fwd2), int'(m_f2));
      chk("rnd_pending", int'(pending), m_pend);
      chk("rnd_full", int'(full), int'(m_full));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Controls the execute-stage operand forwarding path for load results in the VLIW core.
- Tracks in-order outstanding load destinations in a small tag queue.
- Stalls issue when a source register waits on a load that is not returning this cycle.
- Drives the op1/op2 select that steers wb_memdata into the operands when the load returns.

Parameters:
- DEPTH, 4, maximum outstanding loads; power of two, at least 2.
- TAGW, 7, register tag width, laid out as {valid, fromfreg, regnum[4:0]}.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs1  in  TAGW  source 1 tag
- issue_rs2  in  TAGW  source 2 tag
- issue_is_load  in  1  the instruction is a load
- issue_rd  in  TAGW  load destination tag
- wb_mre  in  1  load data returns this cycle
- wb_rd  in  TAGW  destination tag of the returning load
- stall  out  1  hold decode; the instruction is not accepted
- fwd1  out  1  op1 takes wb_memdata
- fwd2  out  1  op2 takes wb_memdata
- pending  out  $clog2(DEPTH+1)  number of outstanding loads
- full  out  1  pending == DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: queue empty, pending=0, full=0.
- stall, fwd1 and fwd2 are combinational. They are 0 while issue_valid=0 (fwd are additionally gated as below).
- Untracked tags:
  - A tag with bit6=0 is never tracked.
  - Integer x0 (tag 7'b100_0000) is never tracked.
  - Neither ever matches.
- Queue:
  - In-order FIFO of tags with read and write pointers that wrap modulo DEPTH.
  - Entry i is valid when its offset from the head is less than pending.
- Push: issue_valid & issue_is_load & !stall & tracked(issue_rd).
- Pop: wb_mre & pending!=0. A wb_mre while empty is ignored.
- Push and pop in the same cycle: pending is unchanged, and both pointers advance.
- Source hazard for a tracked rs:
  - Hazard when rs equals any valid entry, excluding the head entry when pop is asserted this cycle.
  - If a younger entry holds the same tag, the hazard remains.
- Capacity hazard: issue_is_load & full & !wb_mre. A pop in the same cycle frees a slot.
- stall = issue_valid & (hazard(rs1) | hazard(rs2) | capacity hazard).
- Forwarding:
  - fwd1 = issue_rs1[6] & wb_mre & (issue_rs1 == wb_rd).
  - fwd2 is the same for rs2.
  - Forwarding is independent of stall. If forwarding is active, the matching head is excluded from the hazard check.
- WAW: a second load to a register that is already pending is accepted. In-order return guarantees correct tracking.
- Reset while loads are outstanding:
  - The queue is cleared.
  - Returns that arrive after reset are ignored because the queue is empty.
- Latency: a load issued in cycle N can be forwarded to a consumer no earlier than the cycle its wb_mre arrives, which may be N+1.

Optional Feature:
- Macro: SCOREBOARD_CHECK_EN.
- When defined, adds an output port err (1 bit), sticky until rst.
- err is set on either condition:
  - wb_mre with an empty queue.
  - wb_mre with wb_rd not equal to the head tag.
- When undefined, there is no err port and no check logic.

Decomposition:
- Shared package sb_pkg holds:
  - The tag_t typedef.
  - Field constants TAG_VALID=6, TAG_FREG=5, REGNUM width 5.
  - The constant X0_TAG.
  - DEPTH default.
- Sub-module tag_fifo: storage, pointers and count, with the per-entry valid vector exported for the match logic.
- load_scoreboard holds the match, stall and forwarding logic.

Test Plan:
- Issue load rd=7'h41 (x1) at cycle 0. At cycle 1 issue add rs1=7'h41 with wb_mre=0 → stall=1, pending=1. At cycle 2 with wb_mre=1, wb_rd=7'h41 → stall=0, fwd1=1, pending=0 at cycle 3.
- Load to f3 (7'h63), then a consumer with rs2=7'h43 (x3) → stall=0, fwd2=0. Integer and float tags are not aliased.
- Load rd=7'h40 (x0), then a consumer with rs1=7'h40 → no push, pending=0, stall=0.
- Four loads to x1..x4 fill the queue (full=1). A fifth load with wb_mre=0 → stall=1. A fifth load with wb_mre=1 on x1 → accepted, pending stays 4.
- Two loads to x5, then a consumer of x5 with wb_mre for the first → stall=1 (younger entry still pending), fwd1=1.
- With SCOREBOARD_CHECK_EN: wb_mre=1 while empty → err=1 next cycle, and err stays 1 until rst.
